// File: rtl/seq_gen_pkg.sv
// Shared types and constants for the serial pattern generator and its detector.
// State enum, default sync preamble, and elaboration-time sizing helpers.
package seq_gen_pkg;

  typedef enum logic [1:0] {IDLE, PRE, DATA, GAP} state_t;

  localparam int         DEF_PAT_LEN = 4;
  localparam logic [3:0] DEF_PATTERN = 4'b1011;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seq_pattern_gen_if.sv
// Parallel word handshake into the serialiser (valid/ready, word accepted in IDLE only).
interface seq_pattern_gen_if #(
  parameter int WIDTH = 8
) ();
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seq_piso.sv
// Load/shift parallel-in serial-out register; exposes the MSB it will hold after the next edge
// so the caller can register the serial bit without a bubble.
module seq_piso #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb_next
);

  logic [WIDTH-1:0] q, q_n;

  always_comb begin
    q_n = q;
    if (load)       q_n = din;
    else if (shift) q_n = q << 1;
  end

  assign msb_next = q_n[WIDTH-1];

  always_ff @(posedge clk) begin
    if (reset) q <= '0;
    else       q <= q_n;
  end

endmodule

// File: rtl/seq_pattern_gen.sv
// Serialises words MSB-first onto x behind an optional sync preamble, then idles GAP_CYCLES.
// Optional SEQ_GEN_MATCH_CNT_EN adds match_cnt, a count of overlapping preamble hits in the x stream.
module seq_pattern_gen
  import seq_gen_pkg::*;
#(
  parameter int          WIDTH      = 8,
  parameter int          PAT_LEN    = DEF_PAT_LEN,
  parameter logic [31:0] PATTERN    = 32'(DEF_PATTERN),
  parameter int          GAP_CYCLES = 1
`ifdef SEQ_GEN_MATCH_CNT_EN
  ,
  parameter int          CNT_W      = 8
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  seq_pattern_gen_if.slave     bus,
`ifdef SEQ_GEN_MATCH_CNT_EN
  output logic [CNT_W-1:0]     match_cnt,
`endif
  output logic                 x,
  output logic                 x_valid,
  output logic                 busy,
  output logic                 done
);

  localparam int             CW        = clog2(max3(PAT_LEN, WIDTH, GAP_CYCLES) + 1);
  localparam logic [CW-1:0]  PRE_LAST  = CW'((PAT_LEN > 0) ? PAT_LEN - 1 : 0);
  localparam logic [CW-1:0]  DATA_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0]  GAP_LAST  = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          load, shift, msb_n;
  logic          x_d, x_valid_d, done_d;

  function automatic logic pat_bit(input logic [CW-1:0] k);
    int         idx;
    logic [4:0] sel;
    idx = PAT_LEN - 1 - int'(k);
    sel = 5'(idx);
    if (idx < 0 || idx > 31) return 1'b0;
    return PATTERN[sel];
  endfunction

  seq_piso #(.WIDTH(WIDTH)) u_piso (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .shift    (shift),
    .din      (bus.in_data),
    .msb_next (msb_n)
  );

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load    = 1'b0;
    shift   = (state == DATA);
    case (state)
      IDLE: if (bus.in_valid) begin
        load  = 1'b1;
        cnt_n = '0;
        if (PAT_LEN > 0) state_n = PRE;
        else             state_n = DATA;
      end
      PRE: if (cnt == PRE_LAST) begin
        state_n = DATA;
        cnt_n   = '0;
      end else cnt_n = cnt + 1'b1;
      DATA: if (cnt == DATA_LAST) begin
        cnt_n = '0;
        if (GAP_CYCLES > 0) state_n = GAP;
        else                state_n = IDLE;
      end else cnt_n = cnt + 1'b1;
      GAP: if (cnt == GAP_LAST) begin
        state_n = IDLE;
        cnt_n   = '0;
      end else cnt_n = cnt + 1'b1;
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so x is a true flop with no first-bit bubble
  always_comb begin
    x_d       = 1'b0;
    x_valid_d = (state_n == PRE) || (state_n == DATA);
    done_d    = (state_n == DATA) && (cnt_n == DATA_LAST);
    case (state_n)
      PRE:     x_d = pat_bit(cnt_n);
      DATA:    x_d = msb_n;
      default: x_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      x       <= 1'b0;
      x_valid <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      x       <= x_d;
      x_valid <= x_valid_d;
      done    <= done_d;
    end
  end

  assign busy         = (state != IDLE);
  assign bus.in_ready = (state == IDLE);

`ifdef SEQ_GEN_MATCH_CNT_EN
  localparam int HW = (PAT_LEN > 0) ? PAT_LEN : 1;
  localparam int FW = clog2(PAT_LEN + 1) + 1;

  logic [HW-1:0] hist, hist_n;
  logic [FW-1:0] fill, fill_n;
  logic          hit;

  // Gap bits never enter the history; fill stops short patterns matching reset zeros
  always_comb begin
    hist_n = (hist << 1) | HW'(x);
    fill_n = (fill < FW'(PAT_LEN)) ? fill + 1'b1 : fill;
    hit    = x_valid && (PAT_LEN > 0) && (fill_n == FW'(PAT_LEN)) &&
             (hist_n == PATTERN[HW-1:0]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hist      <= '0;
      fill      <= '0;
      match_cnt <= '0;
    end else if (x_valid) begin
      hist <= hist_n;
      fill <= fill_n;
      if (hit && !(&match_cnt)) match_cnt <= match_cnt + 1'b1;
    end
  end
`endif

endmodule
